// File: rtl/wbu_commit_if.sv
`default_nettype none
// =====================================================================
// wbu_commit_if : commit handshake from EXU/LSU into the write-back unit
// Revision 1.0
// =====================================================================
interface wbu_commit_if #(
   parameter int unsigned XLEN = 32
);
   logic            valid;
   logic            ready;
   logic [4:0]      rd;
   logic            gpr_wen;
   logic [XLEN-1:0] wdata;
   logic            csr_wen;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] next_pc;
   logic            trap;
   logic [XLEN-1:0] cause;
   logic            mret;

   modport master (
      output valid, rd, gpr_wen, wdata, csr_wen, csr_addr, csr_wdata,
             next_pc, trap, cause, mret,
      input  ready
   );

   modport slave (
      input  valid, rd, gpr_wen, wdata, csr_wen, csr_addr, csr_wdata,
             next_pc, trap, cause, mret,
      output ready
   );
endinterface
`default_nettype wire

// File: rtl/wbu_commit.sv
`default_nettype none
// =====================================================================
// wbu_commit : GPR file, M-mode CSRs, architectural PC and retire logic
// Revision 1.0
// =====================================================================
module wbu_commit #(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     NR_GPR    = 16,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h8000_0000),
   parameter bit              BYPASS    = 1'b1,
   parameter logic [XLEN-1:0] MVENDORID = XLEN'(32'h7973_7978),
   parameter logic [XLEN-1:0] MARCHID   = '0
) (
   input  wire logic            sys_clk,
   input  wire logic            sys_rst,
   wbu_commit_if.slave          wb,
   input  wire logic [4:0]      gpr_raddr1_i,
   input  wire logic [4:0]      gpr_raddr2_i,
   output logic      [XLEN-1:0] gpr_rdata1_o,
   output logic      [XLEN-1:0] gpr_rdata2_o,
   input  wire logic [11:0]     csr_raddr_i,
   output logic      [XLEN-1:0] csr_rdata_o,
   output logic      [XLEN-1:0] pc_o,
   output logic                 retire_o
);
   localparam int unsigned IDXW          = $clog2(NR_GPR);
   localparam logic [11:0] c_csr_mstatus = 12'h300;
   localparam logic [11:0] c_csr_mtvec   = 12'h305;
   localparam logic [11:0] c_csr_mepc    = 12'h341;
   localparam logic [11:0] c_csr_mcause  = 12'h342;
   localparam logic [11:0] c_csr_mcyc    = 12'hB00;
   localparam logic [11:0] c_csr_mcych   = 12'hB80;
   localparam logic [11:0] c_csr_mins    = 12'hB02;
   localparam logic [11:0] c_csr_minsh   = 12'hB82;
   localparam logic [11:0] c_csr_mvendor = 12'hF11;
   localparam logic [11:0] c_csr_march   = 12'hF12;

   logic [XLEN-1:0] gpr_q [NR_GPR];
   logic [XLEN-1:0] pc_q, pc_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
   logic            mie_q, mie_d, mpie_q, mpie_d;
   logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
   logic            ready_q, retire_q;

   logic            w_commit, w_trap, w_mret, w_retire, w_rd_ok, w_gpr_we, w_csr_we;
   logic            w_byp1, w_byp2;
   logic [XLEN-1:0] w_rf1, w_rf2;

   // trap wins over mret; both only count when the handshake completes
   assign w_commit = wb.valid & ready_q;
   assign w_trap   = w_commit & wb.trap;
   assign w_mret   = w_commit & ~wb.trap & wb.mret;
   assign w_retire = w_commit & ~wb.trap;
   assign w_rd_ok  = (wb.rd != 5'd0) && ({1'b0, wb.rd} < 6'(NR_GPR));
   assign w_gpr_we = w_retire & wb.gpr_wen & w_rd_ok;
   assign w_csr_we = w_retire & wb.csr_wen;

   always_comb begin
      pc_d       = pc_q;
      mtvec_d    = mtvec_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'd0, w_retire};
      // a write to one counter half replaces only that half of the incremented value
      if (w_csr_we) begin
         case (wb.csr_addr)
            c_csr_mstatus: begin
               mie_d  = wb.csr_wdata[3];
               mpie_d = wb.csr_wdata[7];
            end
            c_csr_mtvec:  mtvec_d            = wb.csr_wdata;
            c_csr_mepc:   mepc_d             = wb.csr_wdata;
            c_csr_mcause: mcause_d           = wb.csr_wdata;
            c_csr_mcyc:   mcycle_d[31:0]     = wb.csr_wdata[31:0];
            c_csr_mcych:  mcycle_d[63:32]    = wb.csr_wdata[31:0];
            c_csr_mins:   minstret_d[31:0]   = wb.csr_wdata[31:0];
            c_csr_minsh:  minstret_d[63:32]  = wb.csr_wdata[31:0];
            default: ;
         endcase
      end
      if (w_trap) begin
         pc_d     = mtvec_q & ~XLEN'(3);
         mepc_d   = pc_q;
         mcause_d = wb.cause;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (w_mret) begin
         pc_d   = mepc_q;
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (w_commit) begin
         pc_d = wb.next_pc;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pc_q       <= RESET_PC;
         mtvec_q    <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mcycle_q   <= '0;
         minstret_q <= '0;
         ready_q    <= 1'b1;
         retire_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         mtvec_q    <= mtvec_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
         ready_q    <= w_commit ? ~(wb.trap | wb.mret) : 1'b1;
         retire_q   <= w_retire;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int unsigned i = 0; i < NR_GPR; i++) gpr_q[i] <= '0;
      end else if (w_gpr_we) begin
         gpr_q[wb.rd[IDXW-1:0]] <= wb.wdata;
      end
   end

   assign w_rf1 = (gpr_raddr1_i == 5'd0 || {1'b0, gpr_raddr1_i} >= 6'(NR_GPR))
                  ? '0 : gpr_q[gpr_raddr1_i[IDXW-1:0]];
   assign w_rf2 = (gpr_raddr2_i == 5'd0 || {1'b0, gpr_raddr2_i} >= 6'(NR_GPR))
                  ? '0 : gpr_q[gpr_raddr2_i[IDXW-1:0]];

   generate
      if (BYPASS) begin : g_bypass
         assign w_byp1 = w_gpr_we && (wb.rd == gpr_raddr1_i);
         assign w_byp2 = w_gpr_we && (wb.rd == gpr_raddr2_i);
      end else begin : g_no_bypass
         assign w_byp1 = 1'b0;
         assign w_byp2 = 1'b0;
      end
   endgenerate

   assign gpr_rdata1_o = w_byp1 ? wb.wdata : w_rf1;
   assign gpr_rdata2_o = w_byp2 ? wb.wdata : w_rf2;

   // M-only hart: MPP is hard-wired to 2'b11
   always_comb begin
      csr_rdata_o = '0;
      case (csr_raddr_i)
         c_csr_mstatus: csr_rdata_o = XLEN'({2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0});
         c_csr_mtvec:   csr_rdata_o = mtvec_q;
         c_csr_mepc:    csr_rdata_o = mepc_q;
         c_csr_mcause:  csr_rdata_o = mcause_q;
         c_csr_mcyc:    csr_rdata_o = XLEN'(mcycle_q[31:0]);
         c_csr_mcych:   csr_rdata_o = XLEN'(mcycle_q[63:32]);
         c_csr_mins:    csr_rdata_o = XLEN'(minstret_q[31:0]);
         c_csr_minsh:   csr_rdata_o = XLEN'(minstret_q[63:32]);
         c_csr_mvendor: csr_rdata_o = MVENDORID;
         c_csr_march:   csr_rdata_o = MARCHID;
         default: ;
      endcase
   end

   assign wb.ready = ready_q;
   assign pc_o     = pc_q;
   assign retire_o = retire_q;
endmodule
`default_nettype wire
